uart_mem_loader: RTL
====================

# uart_mem_loader

Serial program loader sitting directly upstream of the multi-cycle CPU's instruction/data memory. Receives 8N1 UART bytes from a host, packs them into 32-bit big-endian words and issues single-cycle word writes to the memory port at consecutive word addresses. While loading, it holds the CPU in reset. The board can therefore be reprogrammed without re-synthesising the memory image.

## Interface

Parameters:
- CLKS_PER_BIT, 868 — clk cycles per UART bit (100 MHz / 115200); must be ≥ 8.
- ADDR_W, 8 — word-index width; memory depth is 2^ADDR_W words.

Ports:
- clk  in  1  — single system clock; all logic on rising edge.
- reset  in  1  — synchronous, active-low; sampled on rising clk edge.
- rx  in  1  — UART serial input, idle high, asynchronous to clk.
- load_en  in  1  — board switch; 1 = loading mode.
- cpu_hold  out  1  — 1 keeps the CPU in reset; ORed into the CPU reset by the top level.
- mem_we  out  1  — one-cycle word write strobe.
- mem_addr  out  32  — byte address = {word_idx, 2'b00}, zero-extended.
- mem_wdata  out  32  — assembled word.
- word_count  out  8  — words written since load start, saturating at 255; drives LEDs.
- frame_err  out  1  — sticky; set on a bad stop bit.

## Operation

- rx passes through a 2-FF synchroniser (rx_s); all decisions use rx_s.
- RX FSM states:
  - IDLE: on rx_s = 0 → START, bit counter cleared.
  - START: at count CLKS_PER_BIT/2 − 1, sample rx_s. If 1, this is a false start → IDLE. If 0 → DATA.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first. After 8 bits → STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, byte is valid → IDLE. If 0, set frame_err, discard the byte, → IDLE. No extra stop-bit wait.
- Packing:
  - Valid bytes are accepted only while load_en = 1.
  - A 2-bit byte_idx selects the byte lane: first byte → [31:24], ..., fourth → [7:0].
  - On the fourth valid byte:
    - mem_wdata takes the completed word.
    - mem_addr takes the current word_idx.
    - mem_we = 1 for exactly one cycle.
    - word_idx increments, wrapping from 2^ADDR_W − 1 to 0.
    - word_count increments, saturating.
  - A discarded (framing-error) byte does not advance byte_idx.
- load_en rising edge (registered compare):
  - word_idx, byte_idx, word_count and frame_err clear.
  - mem_addr returns to 0.
  - cpu_hold = 1 from the following cycle.
- load_en falling edge:
  - A partial word (byte_idx ≠ 0) is dropped and byte_idx clears.
  - cpu_hold = 0 from the following cycle; a mem_we in the same cycle still completes.
- Bytes arriving with load_en = 0 are received and discarded; frame_err is not updated.

## Timing

- Reset values: cpu_hold 0, mem_we 0, mem_addr 0, mem_wdata 0, word_count 0, frame_err 0. FSM resets to IDLE; byte_idx and word_idx reset to 0.
- Reset asserted mid-byte aborts reception immediately; no write occurs.
- Latency from rx edge to FSM response: 2 cycles (synchroniser).
- mem_we asserts on the cycle after the fourth byte's stop-bit sample.
- mem_addr and mem_wdata are stable from the mem_we cycle until the next write.
- Back-to-back bytes with no idle gap are supported: IDLE detects the next start bit on the cycle after STOP.
- Simultaneous events:
  - load_en falling in the cycle a fourth byte completes: the write is performed, then cpu_hold drops.
  - load_en rising in the cycle a byte completes: that byte is discarded.

## Structure

- Shared package loader_pkg:
  - RX state encoding (IDLE, START, DATA, STOP).
  - Default CLKS_PER_BIT.
  - Byte-lane ordering constant.
- Sub-module uart_rx holds the synchroniser, RX FSM and bit/baud counters.
  - Outputs: rx_byte[7:0], rx_valid (1-cycle pulse), rx_ferr (1-cycle pulse).
- uart_mem_loader holds the packing, addressing, load_en edge logic and outputs.

## Test plan

Simulation uses CLKS_PER_BIT = 16.

1. load_en = 1, send 0x20, 0x04, 0x00, 0x05 → one mem_we pulse, mem_addr = 0x00000000, mem_wdata = 0x20040005, word_count = 1, cpu_hold = 1.
2. Send a second word 0x8C, 0x02, 0x00, 0x00 back-to-back with no idle gap → mem_we with mem_addr = 0x00000004, mem_wdata = 0x8C020000, word_count = 2.
3. Send 0xAA with stop bit 0, then 0x11, 0x22, 0x33, 0x44 → frame_err = 1; a single write with mem_wdata = 0x11223344.
4. rx low for 3 cycles, then high → FSM returns to IDLE; no rx_valid, no mem_we.
5. Send 2 bytes, then drop load_en → no mem_we; cpu_hold = 0 next cycle. Raise load_en and send 4 bytes → write at mem_addr = 0.
6. ADDR_W = 2, write 5 words → the 5th write is at mem_addr = 0x00000000. Then assert reset mid-byte → all outputs 0; no write.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: receiver state encoding,
// default baud divisor and the byte-lane ordering used when packing words.
package loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // 100 MHz clock / 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Lane that receives the first byte of a word; big-endian, so the MSB lane.
    localparam logic [1:0] FIRST_LANE = 2'd3;

    // Byte lane (0 = bits [7:0]) written by the byte at position byte_idx.
    function automatic logic [1:0] lane_of(input logic [1:0] byte_idx);
        return FIRST_LANE - byte_idx;
    endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// Word-write port between the loader and the CPU instruction/data memory.
interface uart_mem_loader_if;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: rx synchroniser, receive FSM and baud/bit counters.
// rx_valid and rx_ferr pulse for one cycle on the stop-bit sample.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_s;
    rx_state_t        state,   state_d;
    logic [CNT_W-1:0] cnt,     cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shift,   shift_d;

    // Two-flop synchroniser; resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state, baud counter, bit counter and data shift register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
        end
    end

    // Next-state decode; start bit checked at mid-bit, data and stop one bit period apart.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d   = state;
        cnt_d     = cnt + CNT_W'(1);
        bit_idx_d = bit_idx;
        shift_d   = shift;
        rx_valid  = 1'b0;
        rx_ferr   = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_END) begin
                    cnt_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_END) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift[7:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_END) begin
                    cnt_d    = '0;
                    state_d  = RX_IDLE;
                    rx_valid = rx_s;
                    rx_ferr  = ~rx_s;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte = shift;

endmodule

// File: rtl/uart_mem_loader.sv
// Serial program loader: packs received bytes into big-endian words and
// writes them to consecutive memory words while holding the CPU in reset.
module uart_mem_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              load_en,
    output logic              cpu_hold,
    uart_mem_loader_if.master mem,
    output logic [7:0]        word_count,
    output logic              frame_err
);

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_ferr;
    logic              load_q;
    logic              load_rise;
    logic              load_fall;
    logic              accept;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       word_buf;
    logic [31:0]       word_next;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign load_rise = load_en & ~load_q;
    assign load_fall = ~load_en & load_q;
    // load_q is still high in the falling-edge cycle, so a word completing there is written;
    // it is low in the rising-edge cycle, so a byte completing there is dropped.
    assign accept    = rx_valid & load_q;

    // Current word with the incoming byte merged into its lane.
    always_comb begin
        word_next = word_buf;
        word_next[8 * int'(lane_of(byte_idx)) +: 8] = rx_byte;
    end

    // Load-mode edge handling, byte packing, write strobe and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            load_q        <= 1'b0;
            cpu_hold      <= 1'b0;
            byte_idx      <= '0;
            word_idx      <= '0;
            word_buf      <= '0;
            word_count    <= '0;
            frame_err     <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            load_q     <= load_en;
            cpu_hold   <= load_en;
            mem.mem_we <= 1'b0;
            if (load_rise) begin
                byte_idx     <= '0;
                word_idx     <= '0;
                word_count   <= '0;
                frame_err    <= 1'b0;
                mem.mem_addr <= '0;
            end else begin
                if (accept) begin
                    word_buf <= word_next;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        mem.mem_we    <= 1'b1;
                        mem.mem_wdata <= word_next;
                        mem.mem_addr  <= 32'({word_idx, 2'b00});
                        word_idx      <= word_idx + ADDR_W'(1);
                        if (word_count != 8'hFF) word_count <= word_count + 8'd1;
                    end
                end
                if (load_fall) byte_idx <= '0;
                if (rx_ferr && load_en) frame_err <= 1'b1;
            end
        end
    end

endmodule
